// File: rtl/decode_ctrl_pkg.sv
// Shared types, opcode constants, FSM state encodings and the opcode classifier
// used by the decode controller and its immediate generator.
package decode_ctrl_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic {
        NoGen = 1'b0,
        Gen   = 1'b1
    } ImmGenType;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Only I-format opcodes produce an immediate; everything else, illegal included, is NoGen.
    function automatic ImmGenType classify_opcode(input logic [6:0] opcode);
        ImmGenType kind;
        case (opcode)
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: kind = Gen;
            default:                            kind = NoGen;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/decode_ctrl_imm_gen.sv
// Sign-extends the I-format immediate of the instruction at the decode FIFO head.
import decode_ctrl_pkg::*;

module imm_gen (
    input  u32        instr,
    input  ImmGenType imm_type,
    output u64        imm
);

    logic unused_low_bits;
    assign unused_low_bits = ^instr[19:0];

    always_comb begin
        imm = '0;
        if (imm_type == Gen) begin
            imm = {{52{instr[31]}}, instr[31:20]};
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// Two-entry decode buffer between fetch and execute; classifies each instruction
// at push time and presents the head with its sign-extended immediate.
import decode_ctrl_pkg::*;

module decode_ctrl (
    input  logic      clk,
    input  logic      reset,
    input  logic      if_valid,
    output logic      if_ready,
    input  u32        if_instr,
    input  u64        if_pc,
    input  logic      flush,
    output logic      ex_valid,
    input  logic      ex_ready,
    output u32        ex_instr,
    output u64        ex_pc,
    output ImmGenType ex_imm_type,
    output u64        ex_imm
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       head;
    logic       tail;
    u32         instr_q [2];
    u64         pc_q [2];
    ImmGenType  type_q [2];

    logic push;
    logic pop;

    // Handshakes depend only on registered state, so if_ready never sees ex_ready.
    assign if_ready = (state != ST_FULL);
    assign ex_valid = (state != ST_EMPTY);
    assign push     = if_valid && if_ready;
    assign pop      = ex_valid && ex_ready;

    // Stale slots stay in storage after a pop or flush, so the head is masked when empty.
    always_comb begin
        ex_instr    = '0;
        ex_pc       = '0;
        ex_imm_type = NoGen;
        if (ex_valid) begin
            ex_instr    = instr_q[head];
            ex_pc       = pc_q[head];
            ex_imm_type = type_q[head];
        end
    end

    imm_gen u_imm_gen (
        .instr    (ex_instr),
        .imm_type (ex_imm_type),
        .imm      (ex_imm)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (push) state_next = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_next = ST_FULL;
                else if (pop && !push) state_next = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                type_q[i]  <= NoGen;
            end
        end else if (flush) begin
            state <= ST_EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            state <= state_next;
            if (push) begin
                instr_q[tail] <= if_instr;
                pc_q[tail]    <= if_pc;
                type_q[tail]  <= classify_opcode(if_instr[6:0]);
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed self-checking bench for decode_ctrl: reset, fill/backpressure,
// streaming, flush priority, mid-stream reset and pointer wrap.
import decode_ctrl_pkg::*;

module tb_decode_ctrl;

    logic      clk = 1'b0;
    logic      reset;
    logic      if_valid;
    logic      if_ready;
    u32        if_instr;
    u64        if_pc;
    logic      flush;
    logic      ex_valid;
    logic      ex_ready;
    u32        ex_instr;
    u64        ex_pc;
    ImmGenType ex_imm_type;
    u64        ex_imm;

    int checks = 0;
    int errors = 0;
    int retired = 0;

    decode_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_instr    (ex_instr),
        .ex_pc       (ex_pc),
        .ex_imm_type (ex_imm_type),
        .ex_imm      (ex_imm)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_ex_valid"}, 64'(ex_valid), 64'd0);
        checkOutput({tag, "_if_ready"}, 64'(if_ready), 64'd1);
        checkOutput({tag, "_ex_instr"}, 64'(ex_instr), 64'd0);
        checkOutput({tag, "_ex_pc"}, ex_pc, 64'd0);
        checkOutput({tag, "_ex_imm"}, ex_imm, 64'd0);
        checkOutput({tag, "_ex_imm_type"}, 64'(ex_imm_type), 64'(NoGen));
    endtask

    task automatic checkHead(input string tag, input u32 instr, input u64 pc, input ImmGenType kind, input u64 imm);
        checkOutput({tag, "_ex_valid"}, 64'(ex_valid), 64'd1);
        checkOutput({tag, "_ex_instr"}, 64'(ex_instr), 64'(instr));
        checkOutput({tag, "_ex_pc"}, ex_pc, pc);
        checkOutput({tag, "_ex_imm_type"}, 64'(ex_imm_type), 64'(kind));
        checkOutput({tag, "_ex_imm"}, ex_imm, imm);
    endtask

    task automatic offer(input u32 instr, input u64 pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        u32        wrap_instr [5];
        ImmGenType wrap_type [5];
        u64        wrap_imm [5];

        wrap_instr = '{32'h00700093, 32'h002081B3, 32'hFF810103, 32'h0000006F, 32'h0040809B};
        wrap_type  = '{Gen, NoGen, Gen, NoGen, Gen};
        wrap_imm   = '{64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd4};

        reset    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        checkEmpty("reset");
        reset = 1'b1;
        applyStimulus();
        checkEmpty("post_reset");

        // Single push with execute stalled: all-ones immediate from addi -1.
        offer(32'hFFF00093, 64'h8000_0000);
        applyStimulus();
        if_valid = 1'b0;
        checkHead("push1", 32'hFFF00093, 64'h8000_0000, Gen, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("push1_if_ready", 64'(if_ready), 64'd1);
        ex_ready = 1'b1;
        applyStimulus();
        ex_ready = 1'b0;
        checkEmpty("push1_drain");

        // Fill to FULL, then a third offer must be refused.
        offer(32'h00500113, 64'h100);
        applyStimulus();
        offer(32'h00000033, 64'h104);
        applyStimulus();
        checkOutput("fill_if_ready", 64'(if_ready), 64'd0);
        checkHead("fill_head", 32'h00500113, 64'h100, Gen, 64'd5);
        offer(32'h00A00193, 64'h108);
        applyStimulus();
        checkOutput("third_if_ready", 64'(if_ready), 64'd0);
        checkHead("stall_stable", 32'h00500113, 64'h100, Gen, 64'd5);
        if_valid = 1'b0;
        ex_ready = 1'b1;
        applyStimulus();
        checkHead("pop_second", 32'h00000033, 64'h104, NoGen, 64'd0);
        checkOutput("pop_second_if_ready", 64'(if_ready), 64'd1);
        applyStimulus();
        checkEmpty("fill_drained");
        ex_ready = 1'b0;

        // Sustained simultaneous push/pop in ONE: one retire per cycle, order kept.
        offer({12'd0, 20'h00093}, 64'h1000);
        applyStimulus();
        ex_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer({12'(k + 1), 20'h00093}, 64'h1004 + 64'(4 * k));
            checkHead("stream_head", {12'(k), 20'h00093}, 64'h1000 + 64'(4 * k), Gen, 64'(k));
            if (ex_valid && ex_ready) retired++;
            applyStimulus();
            checkOutput("stream_if_ready", 64'(if_ready), 64'd1);
        end
        checkOutput("stream_retired", 64'(retired), 64'd10);
        if_valid = 1'b0;
        checkHead("stream_last", {12'd10, 20'h00093}, 64'h1028, Gen, 64'd10);
        applyStimulus();
        checkEmpty("stream_drained");
        ex_ready = 1'b0;

        // Flush beats a simultaneous push and pop.
        offer(32'h00100093, 64'h300);
        applyStimulus();
        offer(32'h00200093, 64'h304);
        applyStimulus();
        checkOutput("preflush_if_ready", 64'(if_ready), 64'd0);
        offer(32'h00300093, 64'h308);
        ex_ready = 1'b1;
        flush    = 1'b1;
        applyStimulus();
        flush    = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b0;
        checkEmpty("flush");
        offer(32'h00400093, 64'h30C);
        applyStimulus();
        if_valid = 1'b0;
        checkHead("post_flush", 32'h00400093, 64'h30C, Gen, 64'd4);
        ex_ready = 1'b1;
        applyStimulus();
        ex_ready = 1'b0;
        checkEmpty("post_flush_drain");

        // Reset while FULL discards both entries.
        offer(32'h00500093, 64'h400);
        applyStimulus();
        offer(32'h00600093, 64'h404);
        applyStimulus();
        if_valid = 1'b0;
        reset    = 1'b0;
        applyStimulus();
        reset = 1'b1;
        checkEmpty("mid_reset");
        offer(32'h01000093, 64'h200);
        applyStimulus();
        if_valid = 1'b0;
        checkHead("after_reset", 32'h01000093, 64'h200, Gen, 64'd16);
        ex_ready = 1'b1;
        applyStimulus();
        ex_ready = 1'b0;
        checkEmpty("after_reset_drain");

        // Alternating classes across head/tail wrap.
        for (int k = 0; k < 5; k++) begin
            offer(wrap_instr[k], 64'h500 + 64'(4 * k));
            applyStimulus();
            if_valid = 1'b0;
            checkHead("wrap", wrap_instr[k], 64'h500 + 64'(4 * k), wrap_type[k], wrap_imm[k]);
            ex_ready = 1'b1;
            applyStimulus();
            ex_ready = 1'b0;
            checkOutput("wrap_empty", 64'(ex_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, named as the codebase does.
REQ-002 Ports (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; 0 = reset
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  decode can accept
- if_instr  in  32  raw instruction (u32)
- if_pc  in  64  instruction PC (u64)
- flush  in  1  discard all buffered instructions
- ex_valid  out  1  decoded instruction offered to execute
- ex_ready  in  1  execute accepts
- ex_instr  out  32  raw instruction at head
- ex_pc  out  64  PC at head
- ex_imm_type  out  ImmGenType  immediate-generator select for the head instruction
- ex_imm  out  64  sign-extended immediate for the head (u64)

Function
REQ-003 The block SHALL buffer up to 2 instructions in a FIFO of entries {instr, pc, imm_type}.
REQ-004 The FSM SHALL have states EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-005 A push SHALL occur when if_valid && if_ready; a pop SHALL occur when ex_valid && ex_ready.
REQ-006 if_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL NOT depend combinationally on ex_ready.
REQ-007 ex_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-008 Transitions:
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE.
- FULL: pop -> ONE; no push is possible.
REQ-009 Latency: an instruction pushed at edge N SHALL be presented on ex_* from edge N onward (1-cycle latency); there SHALL be no combinational fetch-to-execute bypass.
REQ-010 Order SHALL be strict FIFO. The head pointer and tail pointer SHALL each be 1 bit and wrap modulo 2.
REQ-011 ex_imm_type SHALL be classified at push time from opcode = if_instr[6:0]:
- Gen for 0010011, 0011011, 0000011 and 1100111.
- NoGen otherwise, including illegal opcodes.
REQ-012 ex_imm SHALL be the combinational output of the imm_gen sub-module driven by the head instr and head imm_type:
- Gen: 52 copies of instr[31] concatenated with instr[31:20].
- NoGen: 0.
REQ-013 flush SHALL force state EMPTY and zero both pointers at the next edge. flush SHALL have priority over a simultaneous push or pop; the pushed instruction is dropped.
REQ-014 While ex_valid=1 and ex_ready=0, ex_instr, ex_pc, ex_imm_type and ex_imm SHALL remain stable.
REQ-015 When ex_valid=0, ex_instr, ex_pc and ex_imm SHALL be 0, and ex_imm_type SHALL be NoGen.

Reset
REQ-016 With reset=0 at an edge, the block SHALL go to state EMPTY with both pointers at 0 and all storage cleared to 0/NoGen.
REQ-017 Outputs during and after reset: if_ready=1, ex_valid=0, ex_* at their REQ-015 values.
REQ-018 Reset SHALL override flush, push and pop. A reset asserted mid-transfer SHALL lose all buffered entries.

Structure
REQ-019 ImmGenType and the opcode constants SHALL live in the shared pipes package. u32/u64 SHALL come from the common package.
REQ-020 One sub-module SHALL be instantiated: imm_gen, fed from the head entry. The opcode classifier SHALL be a package function.
REQ-021 The FSM state SHALL be a package enum, or derived locally from an entry count.

Verification
REQ-022 Push after reset: push addi x1,x0,-1 (0xFFF00093, pc 0x80000000) with ex_ready=0.
- Next cycle: ex_valid=1, ex_imm_type=Gen, ex_imm=0xFFFFFFFFFFFFFFFF.
REQ-023 Fill and backpressure: push 0x00500113 then 0x00000033 with ex_ready=0.
- FULL and if_ready=0.
- A third offer, 0x00A00193, is not accepted.
- Then ex_ready=1: outputs 0x00500113 (imm 5, Gen), then 0x00000033 (NoGen, imm 0), then EMPTY.
REQ-024 Simultaneous push and pop in ONE, sustained for 10 cycles with a PC stream 0x1000, 0x1004, ...:
- 1 instruction retired per cycle, state stays ONE, order preserved, no drops or duplicates.
REQ-025 Flush priority: in FULL, assert flush with if_valid=1 and ex_ready=1 in the same cycle.
- Next cycle: EMPTY, ex_valid=0, nothing popped counted as retired, incoming instruction dropped.
REQ-026 Reset mid-stream: in FULL, drive reset=0 for 1 cycle.
- ex_valid=0, if_ready=1, ex_* zero.
- The next push of 0x01000093 appears as the head with imm 16.
REQ-027 Pointer wrap: run 5 pushes and pops with alternating opcodes (I-type and R-type).
- ex_imm_type alternates Gen/NoGen correctly across the head-pointer wrap.
